// File: rtl/bist_pkg.sv
// Shared types and s1196 defaults for the BIST response analyzer.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int S1196_OUT_WIDTH = 14;
    localparam logic [S1196_OUT_WIDTH-1:0] DEF_POLY = 14'h0443;
    localparam logic [S1196_OUT_WIDTH-1:0] DEF_SEED = 14'h0000;

endpackage

// File: rtl/bist_response_analyzer_if.sv
// Response bus, run control and result signals of the analyzer.
interface bist_response_analyzer_if #(
    parameter int OUT_WIDTH = 14,
    parameter int CNT_W     = 8
);
    logic                 start;
    logic                 abort;
    logic                 resp_valid;
    logic [OUT_WIDTH-1:0] resp_data;
    logic [OUT_WIDTH-1:0] golden;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [OUT_WIDTH-1:0] signature;
    logic [CNT_W-1:0]     resp_count;

    modport master (
        output start, abort, resp_valid, resp_data, golden,
        input  busy, done, pass, signature, resp_count
    );

    modport slave (
        input  start, abort, resp_valid, resp_data, golden,
        output busy, done, pass, signature, resp_count
    );
endinterface

// File: rtl/misr_core.sv
// Galois-form MISR; seed load takes priority over a shift.
module misr_core
    import bist_pkg::*;
#(
    parameter int                   OUT_WIDTH = S1196_OUT_WIDTH,
    parameter logic [OUT_WIDTH-1:0] POLY      = DEF_POLY,
    parameter logic [OUT_WIDTH-1:0] SEED      = DEF_SEED
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_seed,
    input  logic                 shift_en,
    input  logic [OUT_WIDTH-1:0] din,
    output logic [OUT_WIDTH-1:0] sig,
    output logic [OUT_WIDTH-1:0] sig_next
);
    logic [OUT_WIDTH-1:0] r_sig;
    logic [OUT_WIDTH-1:0] w_fb;

    assign w_fb     = r_sig[OUT_WIDTH-1] ? POLY : '0;
    assign sig_next = {r_sig[OUT_WIDTH-2:0], 1'b0} ^ w_fb ^ din;
    assign sig      = r_sig;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sig <= SEED;
        end else if (load_seed) begin
            r_sig <= SEED;
        end else if (shift_en) begin
            r_sig <= sig_next;
        end
    end
endmodule

// File: rtl/bist_response_analyzer.sv
// Compacts CUT responses into a MISR signature and grades it against golden.
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int                   OUT_WIDTH  = S1196_OUT_WIDTH,
    parameter int                   TEST_COUNT = 148,
    parameter logic [OUT_WIDTH-1:0] POLY       = DEF_POLY,
    parameter logic [OUT_WIDTH-1:0] SEED       = DEF_SEED,
    parameter int                   CNT_W      = $clog2(TEST_COUNT + 1)
) (
    input logic                    clk,
    input logic                    reset,
    bist_response_analyzer_if.slave bus
);
    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_count;
    logic                 r_pass;
    logic                 w_start;
    logic                 w_shift;
    logic                 w_final;
    logic                 w_load;
    logic [OUT_WIDTH-1:0] w_sig;
    logic [OUT_WIDTH-1:0] w_sig_next;

    assign w_start = bus.start && (r_state != RUN);
    assign w_shift = (r_state == RUN) && bus.resp_valid && !bus.abort;
    assign w_final = w_shift && (r_count == CNT_W'(TEST_COUNT - 1));
    assign w_load  = bus.abort || w_start;

    misr_core #(
        .OUT_WIDTH (OUT_WIDTH),
        .POLY      (POLY),
        .SEED      (SEED)
    ) u_misr (
        .clk       (clk),
        .reset     (reset),
        .load_seed (w_load),
        .shift_en  (w_shift),
        .din       (bus.resp_data),
        .sig       (w_sig),
        .sig_next  (w_sig_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.abort) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE, DONE: if (bus.start) w_state_next = RUN;
                RUN:        if (w_final)   w_state_next = DONE;
                default:                   w_state_next = IDLE;
            endcase
        end
    end

    // pass grades the value being loaded on the final edge, not the old one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_pass  <= 1'b0;
        end else if (w_load) begin
            r_count <= '0;
            r_pass  <= 1'b0;
        end else if (w_shift) begin
            r_count <= r_count + CNT_W'(1);
            if (w_final) begin
                r_pass <= (w_sig_next == bus.golden);
            end
        end
    end

    assign bus.busy       = (r_state == RUN);
    assign bus.done       = (r_state == DONE);
    assign bus.pass       = r_pass;
    assign bus.signature  = w_sig;
    assign bus.resp_count = r_count;
endmodule

// File: tb/tb_bist_response_analyzer.sv
// Directed self-checking bench for bist_response_analyzer.
module tb_bist_response_analyzer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    bist_response_analyzer_if #(.OUT_WIDTH(14), .CNT_W(2)) ia ();
    bist_response_analyzer_if #(.OUT_WIDTH(14), .CNT_W(8)) ib ();

    bist_response_analyzer #(.TEST_COUNT(2)) ua (
        .clk   (clk),
        .reset (reset),
        .bus   (ia.slave)
    );

    bist_response_analyzer #(.TEST_COUNT(148)) ub (
        .clk   (clk),
        .reset (reset),
        .bus   (ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_b_zeros(input int n);
        for (int i = 0; i < n; i++) begin
            ib.resp_valid = 1'b1;
            ib.resp_data  = 14'h0000;
            step();
        end
        ib.resp_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        ia.start = 0; ia.abort = 0; ia.resp_valid = 0;
        ia.resp_data = '0; ia.golden = '0;
        ib.start = 0; ib.abort = 0; ib.resp_valid = 0;
        ib.resp_data = '0; ib.golden = '0;

        // reset with resp_valid toggling
        for (int i = 0; i < 4; i++) begin
            ia.resp_valid = i[0];
            ia.resp_data  = 14'h1234;
            step();
        end
        chk("rst_sig",   ia.signature,  14'h0000);
        chk("rst_busy",  ia.busy,       1'b0);
        chk("rst_done",  ia.done,       1'b0);
        chk("rst_pass",  ia.pass,       1'b0);
        chk("rst_count", ia.resp_count, 2'd0);
        ia.resp_valid = 0;
        reset = 1'b1;
        step();

        // TC=2: 2000 then 0000, golden 0443
        ia.start = 1; step();
        ia.start = 0;
        chk("a_start_busy", ia.busy, 1'b1);
        ia.resp_valid = 1; ia.resp_data = 14'h2000; ia.golden = 14'h0443;
        step();
        chk("a_sig1",   ia.signature,  14'h2000);
        chk("a_count1", ia.resp_count, 2'd1);
        ia.resp_data = 14'h0000;
        step();
        ia.resp_valid = 0;
        chk("a_sig2",   ia.signature,  14'h0443);
        chk("a_done",   ia.done,       1'b1);
        chk("a_pass",   ia.pass,       1'b1);
        chk("a_count2", ia.resp_count, 2'd2);
        chk("a_busy0",  ia.busy,       1'b0);

        // resp_valid in DONE is ignored
        ia.resp_valid = 1; ia.resp_data = 14'h0001; step();
        ia.resp_valid = 0; step();
        chk("a_done_sig",   ia.signature,  14'h0443);
        chk("a_done_count", ia.resp_count, 2'd2);
        chk("a_done_pass",  ia.pass,       1'b1);

        // TC=2: 0001, gap, 0001 with golden 0 -> 0003, fail
        ia.start = 1; step();
        ia.start = 0;
        chk("b_restart_sig",  ia.signature, 14'h0000);
        chk("b_restart_done", ia.done,      1'b0);
        chk("b_restart_pass", ia.pass,      1'b0);
        ia.resp_valid = 1; ia.resp_data = 14'h0001; ia.golden = 14'h0000;
        step();
        ia.resp_valid = 0;
        ia.start = 1; step();
        ia.start = 0; step();
        chk("b_gap_sig",   ia.signature,  14'h0001);
        chk("b_gap_count", ia.resp_count, 2'd1);
        chk("b_gap_busy",  ia.busy,       1'b1);
        ia.resp_valid = 1; ia.resp_data = 14'h0001; step();
        ia.resp_valid = 0;
        chk("b_sig",  ia.signature, 14'h0003);
        chk("b_done", ia.done,      1'b1);
        chk("b_pass", ia.pass,      1'b0);

        // TC=148 all-zero run, golden 0
        ib.golden = 14'h0000;
        ib.start = 1; step();
        ib.start = 0;
        run_b_zeros(147);
        chk("c_147_busy",  ib.busy,       1'b1);
        chk("c_147_count", ib.resp_count, 8'd147);
        run_b_zeros(1);
        chk("c_sig",   ib.signature,  14'h0000);
        chk("c_done",  ib.done,       1'b1);
        chk("c_pass",  ib.pass,       1'b1);
        chk("c_count", ib.resp_count, 8'd148);

        // same run, golden 0001
        ib.golden = 14'h0001;
        ib.start = 1; step();
        ib.start = 0;
        run_b_zeros(148);
        chk("d_done", ib.done, 1'b1);
        chk("d_pass", ib.pass, 1'b0);

        // abort after 50 responses, with start and resp_valid also high
        ib.start = 1; step();
        ib.start = 0;
        for (int i = 0; i < 50; i++) begin
            ib.resp_valid = 1; ib.resp_data = 14'h0001; step();
        end
        ib.resp_valid = 0;
        chk("e_count50", ib.resp_count, 8'd50);
        ib.abort = 1; ib.start = 1; ib.resp_valid = 1; step();
        ib.abort = 0; ib.start = 0; ib.resp_valid = 0;
        chk("e_abort_sig",   ib.signature,  14'h0000);
        chk("e_abort_count", ib.resp_count, 8'd0);
        chk("e_abort_busy",  ib.busy,       1'b0);
        chk("e_abort_done",  ib.done,       1'b0);
        ib.golden = 14'h0000;
        ib.start = 1; step();
        ib.start = 0;
        run_b_zeros(148);
        chk("e_rerun_done",  ib.done,       1'b1);
        chk("e_rerun_pass",  ib.pass,       1'b1);
        chk("e_rerun_count", ib.resp_count, 8'd148);

        // async reset mid-run after 10 ones: 03ff
        ib.start = 1; step();
        ib.start = 0;
        for (int i = 0; i < 10; i++) begin
            ib.resp_valid = 1; ib.resp_data = 14'h0001; step();
        end
        ib.resp_valid = 0;
        chk("f_sig10",   ib.signature,  14'h03ff);
        chk("f_count10", ib.resp_count, 8'd10);
        #2 reset = 1'b0;
        #1;
        chk("f_rst_sig",   ib.signature,  14'h0000);
        chk("f_rst_count", ib.resp_count, 8'd0);
        chk("f_rst_busy",  ib.busy,       1'b0);
        chk("f_rst_pass",  ib.pass,       1'b0);
        step();
        reset = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bist_response_analyzer.md
Name: bist_response_analyzer

Overview:
- Response-side end of the s1196 fault-simulation/BIST flow. The pattern source drives the CUT; this block is the other end.
- Compacts the CUT's primary-output responses into a MISR signature over a fixed number of test vectors.
- At the end of the run, compares the signature against a golden signature and reports pass/fail.
- Sits beside the CUT instance. Takes the CUT's output bus plus a per-vector valid strobe from the pattern-source side.

Parameters:
- OUT_WIDTH, 14, width of CUT response bus and MISR.
- TEST_COUNT, 148, number of valid responses compacted per run (>=1).
- POLY, 14'h0443, Galois feedback mask (x^14+x^10+x^6+x+1, x^14 implicit); bit i = tap on x^i.
- SEED, 14'h0000, MISR value loaded on start.
- CNT_W, $clog2(TEST_COUNT+1), response counter width (derived).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a compaction run (sampled in IDLE or DONE).
- abort  in  1  synchronous return to IDLE from any state.
- resp_valid  in  1  resp_data holds one CUT response this cycle.
- resp_data  in  OUT_WIDTH  CUT primary-output response.
- golden  in  OUT_WIDTH  expected signature; sampled on the final compaction cycle.
- busy  out  1  high in RUN.
- done  out  1  high in DONE (level, held until start/abort).
- pass  out  1  valid when done=1: signature==golden.
- signature  out  OUT_WIDTH  current MISR contents.
- resp_count  out  CNT_W  responses compacted in current run.

Behaviour:
- Reset (reset=0, async): state=IDLE, signature=SEED, resp_count=0, busy=0, done=0, pass=0.
- States: IDLE, RUN, DONE.
- IDLE/DONE, start=1: next cycle state=RUN, signature=SEED, resp_count=0, pass=0, done=0.
- RUN, resp_valid=1:
  - sig_next = {sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0) ^ resp_data.
  - resp_count increments.
  - Update is visible one cycle after the valid edge; latency is 1 clk.
- RUN, resp_valid=0: hold signature and count. Gaps between vectors are legal.
- Final response: when resp_valid=1 and resp_count==TEST_COUNT-1, the same edge:
  - loads sig_next;
  - sets resp_count=TEST_COUNT;
  - sets pass=(sig_next==golden);
  - sets state=DONE, done=1.
- pass is a registered compare against sig_next, not the old signature.
- DONE: signature, resp_count and pass are frozen. resp_valid is ignored.
- Ignored inputs:
  - resp_valid in IDLE or DONE.
  - start while in RUN (no restart).
- abort=1 in any state: next cycle IDLE, signature=SEED, resp_count=0, done=0, pass=0. abort has priority over start and resp_valid.
- Async reset mid-RUN: immediate return to reset values. The partial signature is discarded.
- TEST_COUNT=1: the first valid response goes straight to DONE.
- Arithmetic: all MISR math is bitwise GF(2) and fixed at OUT_WIDTH; no carries. resp_count never wraps (max TEST_COUNT).

Decomposition:
- Shared package bist_pkg:
  - state enum {IDLE, RUN, DONE};
  - default POLY and SEED constants;
  - OUT_WIDTH=14 for s1196.
- Sub-module misr_core:
  - parameterised by OUT_WIDTH, POLY, SEED;
  - inputs clk, reset, load_seed, shift_en, din;
  - output sig.
- The FSM, counter and compare stay in the top module.

Test Plan:
- Reset with resp_valid toggling -> signature=14'h0000, busy=0, done=0, pass=0, resp_count=0.
- TEST_COUNT=2, start, then resp_data 14'h2000, then 14'h0000, golden=14'h0443 -> signature 14'h2000 after first, 14'h0443 after second; done=1, pass=1, resp_count=2.
- TEST_COUNT=2, responses 14'h0001,14'h0001 with two idle cycles between, golden=14'h0000 -> signature 14'h0003, done=1, pass=0.
- Default params, 148 responses of 14'h0000, golden=0 -> signature 0, pass=1. Repeat with golden=14'h0001 -> pass=0.
- abort asserted mid-run after 50 responses -> IDLE next cycle, signature=SEED, resp_count=0. A new start then completes normally after 148 more responses.
- Async reset asserted mid-RUN between clock edges -> outputs reach reset values without a clock edge. start during RUN and resp_valid in DONE produce no change.
